// File: rtl/updown_count_seq_ctrl_if.sv
// Command/status bundle between a run requester and the up/down count sequencer.
// The requester drives start/stop/pause and the range config; the sequencer reports status.
interface updown_count_seq_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int PASS_W = 8
);
  logic              start;
  logic              stop;
  logic              pause;
  logic [1:0]        cfg_mode;
  logic [WIDTH-1:0]  cfg_low;
  logic [WIDTH-1:0]  cfg_high;
  logic [PASS_W-1:0] cfg_passes;
  logic [WIDTH-1:0]  count;
  logic              mode;
  logic              busy;
  logic              tc;
  logic              done;
  logic              err;

  modport master (
    output start, stop, pause, cfg_mode, cfg_low, cfg_high, cfg_passes,
    input  count, mode, busy, tc, done, err
  );

  modport slave (
    input  start, stop, pause, cfg_mode, cfg_low, cfg_high, cfg_passes,
    output count, mode, busy, tc, done, err
  );
endinterface

// File: rtl/updown_count_seq_ctrl.sv
// Run controller for the 8-bit up/down counter: one-shot up/down, wrapping up and
// ping-pong sequencing over a latched [low..high] range with a terminal-count budget.
module updown_count_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int PASS_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  updown_count_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;

  localparam logic [WIDTH-1:0]  ONE_C = 1;
  localparam logic [PASS_W-1:0] ONE_P = 1;

  state_e            state_q;
  logic [WIDTH-1:0]  count_q, low_q, high_q;
  logic [1:0]        run_mode_q;
  logic [PASS_W-1:0] passes_q, pass_q;
  logic              mode_q, err_q;

  logic at_bound, advancing, tc_w, done_w, last_pass, accept, flat;

  // Terminal bound depends on the run mode and, in ping-pong, on the current direction.
  always_comb begin
    at_bound = 1'b0;
    case (run_mode_q)
      2'b00, 2'b10: at_bound = (count_q == high_q);
      2'b01:        at_bound = (count_q == low_q);
      default:      at_bound = mode_q ? (count_q == low_q) : (count_q == high_q);
    endcase
  end

  assign advancing = (state_q == RUN) && !bus.stop && !bus.pause;
  assign tc_w      = advancing && at_bound;
  assign last_pass = (passes_q != '0) && ((pass_q + ONE_P) == passes_q);
  assign done_w    = tc_w && (run_mode_q[1] ? last_pass : 1'b1);
  assign accept    = ((state_q == IDLE) || (state_q == DONE)) && bus.start && !bus.stop;
  assign flat      = (low_q == high_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      pass_q     <= '0;
      low_q      <= '0;
      high_q     <= '0;
      passes_q   <= '0;
      run_mode_q <= 2'b00;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (accept) begin
            if (bus.cfg_low > bus.cfg_high) begin
              err_q <= 1'b1;
            end else begin
              state_q    <= RUN;
              low_q      <= bus.cfg_low;
              high_q     <= bus.cfg_high;
              passes_q   <= bus.cfg_passes;
              run_mode_q <= bus.cfg_mode;
              pass_q     <= '0;
              if (bus.cfg_mode == 2'b01) begin
                count_q <= bus.cfg_high;
                mode_q  <= 1'b1;
              end else begin
                count_q <= bus.cfg_low;
                mode_q  <= 1'b0;
              end
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_q <= IDLE;
          end else if (bus.pause) begin
            state_q <= HOLD;
          end else if (done_w) begin
            state_q <= DONE;
            pass_q  <= pass_q + ONE_P;
          end else begin
            if (tc_w) pass_q <= pass_q + ONE_P;
            case (run_mode_q)
              2'b00:   count_q <= count_q + ONE_C;
              2'b01:   count_q <= count_q - ONE_C;
              2'b10:   count_q <= at_bound ? low_q : count_q + ONE_C;
              default: begin
                // Reversal steps one inside the range, unless the range is a single value.
                if (!mode_q) begin
                  if (at_bound) begin
                    mode_q  <= 1'b1;
                    count_q <= flat ? high_q : high_q - ONE_C;
                  end else begin
                    count_q <= count_q + ONE_C;
                  end
                end else begin
                  if (at_bound) begin
                    mode_q  <= 1'b0;
                    count_q <= flat ? low_q : low_q + ONE_C;
                  end else begin
                    count_q <= count_q - ONE_C;
                  end
                end
              end
            endcase
          end
        end
        HOLD: begin
          if (bus.stop)        state_q <= IDLE;
          else if (!bus.pause) state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.mode  = mode_q;
  assign bus.busy  = (state_q == RUN) || (state_q == HOLD);
  assign bus.tc    = tc_w;
  assign bus.done  = done_w;
  assign bus.err   = err_q;

endmodule
